// File: rtl/header_receiver_if.sv
// Header receiver bus: UART byte handshake on one side, assembled header and
// status towards the consumer on the other.
interface header_receiver_if #(
    parameter int unsigned HEADER_BYTES = 80
);
    // UART receiver side
    logic [7:0]                  rx_data;
    logic                        rx_ready;
    logic                        rx_clear;

    // Consumer side
    logic                        header_ack;
    logic [8*HEADER_BYTES-1:0]   header_data;
    logic                        header_valid;
    logic                        header_ready;

    // Status
    logic [6:0]                  byte_count;
    logic                        busy;
    logic                        frame_error;

    // Environment: UART receiver plus header consumer
    modport master (
        output rx_data,
        output rx_ready,
        output header_ack,
        input  rx_clear,
        input  header_data,
        input  header_valid,
        input  header_ready,
        input  byte_count,
        input  busy,
        input  frame_error
    );

    // The header receiver itself
    modport slave (
        input  rx_data,
        input  rx_ready,
        input  header_ack,
        output rx_clear,
        output header_data,
        output header_valid,
        output header_ready,
        output byte_count,
        output busy,
        output frame_error
    );
endinterface

// File: rtl/header_receiver.sv
// Assembles HEADER_BYTES consecutive UART bytes into one block header.
// Each byte is acknowledged with a one-cycle rx_clear, and the receiver then
// waits for rx_ready to fall so a byte is never taken twice. A completed
// header is published atomically on header_data; a stalled partial header is
// dropped after TIMEOUT_CYCLES idle cycles and flagged with frame_error.
module header_receiver #(
    parameter int unsigned HEADER_BYTES   = 80,
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
    input  logic             clock,
    input  logic             reset,
    header_receiver_if.slave bus
);
    localparam int unsigned     HdrW    = 8 * HEADER_BYTES;
    // Shadow only holds the bytes preceding the final one; the final byte
    // comes straight from rx_data on the completing edge.
    localparam int unsigned     ShadowW = HdrW - 8;
    localparam int unsigned     CntW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] IdleMax = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]      LastIdx = 7'(HEADER_BYTES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StAck
    } state_e;

    state_e               state_q, state_d;
    logic [ShadowW-1:0]   shadow_q, shadow_d;
    logic [HdrW-1:0]      header_q, header_d;
    logic [6:0]           count_q, count_d;
    logic [CntW-1:0]      idle_q, idle_d;
    logic                 rx_clear_q, rx_clear_d;
    logic                 valid_q, valid_d;
    logic                 ready_q, ready_d;
    logic                 ferr_q, ferr_d;

    logic                 capture;
    logic                 last_byte;
    logic                 timeout;
    logic [HdrW-1:0]      shifted;
    logic [CntW-1:0]      idle_inc;

    // Decode the events of the current cycle
    always_comb begin
        capture   = (state_q != StAck) && bus.rx_ready;
        last_byte = (count_q == LastIdx);
        shifted   = {shadow_q, bus.rx_data};
        // Saturate so a parked ACK after completion cannot wrap the counter
        idle_inc  = (idle_q == IdleMax) ? idle_q : idle_q + CntW'(1);
        // Only a partial header can time out; capture on the same edge wins
        timeout   = (state_q != StIdle) && (count_q != 7'd0) &&
                    (idle_q == IdleMax) && !capture;
    end

    // Next-state logic for the FSM, datapath and pulse outputs
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        header_d   = header_q;
        count_d    = count_q;
        idle_d     = idle_q;
        rx_clear_d = 1'b0;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        // Completion below overrides a coincident acknowledge
        ready_d    = bus.header_ack ? 1'b0 : ready_q;

        if (capture) begin
            shadow_d   = shifted[ShadowW-1:0];
            rx_clear_d = 1'b1;
            idle_d     = '0;
            state_d    = StAck;
            if (last_byte) begin
                header_d = shifted;
                valid_d  = 1'b1;
                ready_d  = 1'b1;
                count_d  = 7'd0;
            end else begin
                count_d  = count_q + 7'd1;
            end
        end else if (timeout) begin
            shadow_d = '0;
            count_d  = 7'd0;
            idle_d   = '0;
            ferr_d   = 1'b1;
            state_d  = StIdle;
        end else begin
            unique case (state_q)
                StIdle: idle_d = '0;
                StRecv: idle_d = idle_inc;
                StAck: begin
                    idle_d = idle_inc;
                    if (!bus.rx_ready) begin
                        // byte_count of 0 here means a header just completed
                        if (count_q == 7'd0) begin
                            state_d = StIdle;
                            idle_d  = '0;
                        end else begin
                            state_d = StRecv;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and registered outputs, cleared asynchronously by reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            shadow_q   <= '0;
            header_q   <= '0;
            count_q    <= 7'd0;
            idle_q     <= '0;
            rx_clear_q <= 1'b0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            header_q   <= header_d;
            count_q    <= count_d;
            idle_q     <= idle_d;
            rx_clear_q <= rx_clear_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            ferr_q     <= ferr_d;
        end
    end

    // Drive the interface from the registers
    always_comb begin
        bus.rx_clear     = rx_clear_q;
        bus.header_data  = header_q;
        bus.header_valid = valid_q;
        bus.header_ready = ready_q;
        bus.byte_count   = count_q;
        bus.busy         = (state_q != StIdle);
        bus.frame_error  = ferr_q;
    end

endmodule
